// File: rtl/alarm_timekeeper.sv
// Alarm clock time base: 24-hour BCD time, alarm register and clock/set/ring mode FSM.
// Define ALARM_MSG_EN to replace the time digits with "SEtA"/"ALAm" messages.
module alarm_timekeeper #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int RING_SECS     = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_hour,
    input  logic       btn_min,
    input  logic       btn_stop,
    output logic [5:0] sec,
    output logic [3:0] min2,
    output logic [3:0] min1,
    output logic [3:0] H2,
    output logic [2:0] H1,
    output logic [3:0] Amin2,
    output logic [3:0] Amin1,
    output logic [3:0] AH2,
    output logic [1:0] AH1,
    output logic       condition,
    output logic       armed,
    output logic       buzzer
);
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    typedef enum logic [1:0] {CLOCK, SET_TIME, SET_ALARM, RING} state_t;

    state_t        state_reg;
    logic [PW-1:0] presc_reg;
    logic [5:0]    sec_reg;
    logic [3:0]    min2_reg, min1_reg, h2_reg;
    logic [1:0]    h1_reg;
    logic [3:0]    amin2_reg, amin1_reg, ah2_reg;
    logic [1:0]    ah1_reg;
    logic [5:0]    ring_cnt_reg;
    logic          armed_reg, buzzer_reg, condition_reg;
`ifdef ALARM_MSG_EN
    logic          seta_msg_reg;
`endif

    // Minute/hour increments without carry out; tens/units packed as {tens, units}.
    function automatic logic [7:0] min_inc(input logic [3:0] tens, input logic [3:0] units);
        if (units == 4'd9)
            return {((tens == 4'd5) ? 4'd0 : tens + 4'd1), 4'd0};
        return {tens, units + 4'd1};
    endfunction

    function automatic logic [5:0] hour_inc(input logic [1:0] tens, input logic [3:0] units);
        if (tens == 2'd2 && units == 4'd3)
            return 6'd0;
        if (units == 4'd9)
            return {tens + 2'd1, 4'd0};
        return {tens, units + 4'd1};
    endfunction

    logic       tick, count_en, alarm_hit;
    logic [5:0] sec_next;
    logic [3:0] min2_next, min1_next, h2_next;
    logic [1:0] h1_next;
    logic [7:0] min_btn, amin_btn;
    logic [5:0] hour_btn, ahour_btn;

    always_comb begin
        tick      = (presc_reg == PW'(TICKS_PER_SEC - 1));
        count_en  = !(state_reg == SET_TIME) && !(state_reg == CLOCK && btn_mode);
        min_btn   = min_inc(min1_reg, min2_reg);
        hour_btn  = hour_inc(h1_reg, h2_reg);
        amin_btn  = min_inc(amin1_reg, amin2_reg);
        ahour_btn = hour_inc(ah1_reg, ah2_reg);

        // Time as it will read after this tick, with the full seconds->hours carry chain.
        sec_next  = (sec_reg == 6'd59) ? 6'd0 : sec_reg + 6'd1;
        min2_next = min2_reg;
        min1_next = min1_reg;
        h2_next   = h2_reg;
        h1_next   = h1_reg;
        if (sec_reg == 6'd59) begin
            {min1_next, min2_next} = min_btn;
            if (min1_reg == 4'd5 && min2_reg == 4'd9)
                {h1_next, h2_next} = hour_btn;
        end
        alarm_hit = armed_reg && (sec_reg == 6'd59) &&
                    ({h1_next, h2_next, min1_next, min2_next} ==
                     {ah1_reg, ah2_reg, amin1_reg, amin2_reg});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= CLOCK;
            presc_reg     <= '0;
            sec_reg       <= '0;
            min2_reg      <= '0;
            min1_reg      <= '0;
            h2_reg        <= '0;
            h1_reg        <= '0;
            amin2_reg     <= '0;
            amin1_reg     <= '0;
            ah2_reg       <= 4'd7;
            ah1_reg       <= '0;
            ring_cnt_reg  <= '0;
            armed_reg     <= 1'b0;
            buzzer_reg    <= 1'b0;
            condition_reg <= 1'b0;
`ifdef ALARM_MSG_EN
            seta_msg_reg  <= 1'b0;
`endif
        end else begin
            // Entering or sitting in SET_TIME freezes the seconds at a clean 0.
            if (!count_en) begin
                presc_reg <= '0;
                sec_reg   <= '0;
            end else if (tick) begin
                presc_reg <= '0;
                sec_reg   <= sec_next;
                min2_reg  <= min2_next;
                min1_reg  <= min1_next;
                h2_reg    <= h2_next;
                h1_reg    <= h1_next;
            end else begin
                presc_reg <= presc_reg + PW'(1);
            end

            case (state_reg)
                CLOCK: begin
                    if (btn_mode)
                        state_reg <= SET_TIME;
                    else if (btn_stop)
                        armed_reg <= ~armed_reg;
                    else if (tick && alarm_hit) begin
                        state_reg    <= RING;
                        buzzer_reg   <= 1'b1;
                        ring_cnt_reg <= '0;
                    end
                end
                SET_TIME: begin
                    if (btn_mode) begin
                        state_reg <= SET_ALARM;
`ifdef ALARM_MSG_EN
                        seta_msg_reg <= 1'b1;
`else
                        condition_reg <= 1'b1;
`endif
                    end else if (!btn_stop) begin
                        if (btn_hour)
                            {h1_reg, h2_reg} <= hour_btn;
                        else if (btn_min)
                            {min1_reg, min2_reg} <= min_btn;
                    end
                end
                SET_ALARM: begin
                    if (btn_mode) begin
                        state_reg     <= CLOCK;
                        condition_reg <= 1'b0;
`ifdef ALARM_MSG_EN
                        seta_msg_reg  <= 1'b0;
`endif
                    end else begin
`ifdef ALARM_MSG_EN
                        // Prescaler restarted at entry, so its first tick ends the message.
                        if (tick && seta_msg_reg) begin
                            seta_msg_reg  <= 1'b0;
                            condition_reg <= 1'b1;
                        end
`endif
                        if (!btn_stop) begin
                            if (btn_hour)
                                {ah1_reg, ah2_reg} <= ahour_btn;
                            else if (btn_min)
                                {amin1_reg, amin2_reg} <= amin_btn;
                        end
                    end
                end
                RING: begin
                    if (btn_stop || (tick && ring_cnt_reg == 6'(RING_SECS - 1))) begin
                        state_reg  <= CLOCK;
                        buzzer_reg <= 1'b0;
                    end else if (tick)
                        ring_cnt_reg <= ring_cnt_reg + 6'd1;
                end
                default: state_reg <= CLOCK;
            endcase
        end
    end

    always_comb begin
        sec       = sec_reg;
        min2      = min2_reg;
        min1      = min1_reg;
        H2        = h2_reg;
        H1        = {1'b0, h1_reg};
        condition = condition_reg;
`ifdef ALARM_MSG_EN
        if (state_reg == RING) begin
            H1   = 3'b111;
            H2   = 4'b1111;
            min1 = 4'b1111;
            min2 = 4'b1111;
        end else if (seta_msg_reg) begin
            H1   = 3'b011;
            H2   = 4'b1010;
            min1 = 4'b1010;
            min2 = 4'b1010;
        end
`endif
    end

    assign Amin2  = amin2_reg;
    assign Amin1  = amin1_reg;
    assign AH2    = ah2_reg;
    assign AH1    = ah1_reg;
    assign armed  = armed_reg;
    assign buzzer = buzzer_reg;

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Directed bench for alarm_timekeeper: vector table for button handling plus
// hand sequences for tick spacing, rollover, ring entry/exit and reset.
module tb_alarm_timekeeper;
`ifdef ALARM_MSG_EN
    localparam bit MSG = 1'b1;
`else
    localparam bit MSG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0, btn_hour = 1'b0, btn_min = 1'b0, btn_stop = 1'b0;
    logic [5:0] sec;
    logic [3:0] min2, min1, H2, Amin2, Amin1, AH2;
    logic [2:0] H1;
    logic [1:0] AH1;
    logic       condition, armed, buzzer;

    int checks = 0;
    int failures = 0;

    alarm_timekeeper #(.TICKS_PER_SEC(4), .RING_SECS(3)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_hour(btn_hour), .btn_min(btn_min), .btn_stop(btn_stop),
        .sec(sec), .min2(min2), .min1(min1), .H2(H2), .H1(H1),
        .Amin2(Amin2), .Amin1(Amin1), .AH2(AH2), .AH1(AH1),
        .condition(condition), .armed(armed), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   wait_cyc;
        logic mode, hour, mn, stop;
        logic chk_time;
        int   h1, h2, m1, m2, ah1, ah2, am1, am2, cond, arm;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        {btn_mode, btn_hour, btn_min, btn_stop} = 4'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Called on a negedge; holds the buttons through exactly one rising edge.
    task automatic press(input logic m, input logic h, input logic mn, input logic s);
        {btn_mode, btn_hour, btn_min, btn_stop} = {m, h, mn, s};
        @(negedge clk);
        {btn_mode, btn_hour, btn_min, btn_stop} = 4'b0;
    endtask

    task automatic wait_sec59();
        int n = 0;
        while (sec != 6'd59 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("reach_sec59", sec, 59);
    endtask

    // Reset, set time HH:MM:00 via SET_TIME, return to CLOCK, optionally arm, wait for :59.
    task automatic setup_time(input int hp, input int mp, input bit arm);
        do_reset();
        press(1, 0, 0, 0);
        repeat (hp) press(0, 1, 0, 0);
        repeat (mp) press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        if (arm) press(0, 0, 0, 1);
        wait_sec59();
    endtask

    task automatic chk_ring_display(input string name);
        chk({name, "_H1"}, H1, MSG ? 7 : 0);
        chk({name, "_H2"}, H2, MSG ? 15 : 7);
        chk({name, "_min1"}, min1, MSG ? 15 : 0);
        chk({name, "_min2"}, min2, MSG ? 15 : 0);
    endtask

    initial begin
        // wait, mode,hour,min,stop, chk_time, h1,h2,m1,m2, ah1,ah2,am1,am2, cond, armed
        vecs[0]  = '{0, 0,0,0,1, 1, 0,0,0,0, 0,7,0,0, 0, 1};
        vecs[1]  = '{0, 0,1,0,0, 1, 0,0,0,0, 0,7,0,0, 0, 1};
        vecs[2]  = '{0, 0,0,1,0, 1, 0,0,0,0, 0,7,0,0, 0, 1};
        vecs[3]  = '{0, 0,0,0,1, 1, 0,0,0,0, 0,7,0,0, 0, 0};
        vecs[4]  = '{0, 1,0,0,0, 1, 0,0,0,0, 0,7,0,0, 0, 0};
        vecs[5]  = '{0, 0,1,0,0, 1, 0,1,0,0, 0,7,0,0, 0, 0};
        vecs[6]  = '{0, 0,1,1,0, 1, 0,2,0,0, 0,7,0,0, 0, 0};
        vecs[7]  = '{0, 0,0,1,0, 1, 0,2,0,1, 0,7,0,0, 0, 0};
        vecs[8]  = '{0, 0,0,1,1, 1, 0,2,0,1, 0,7,0,0, 0, 0};
        vecs[9]  = '{0, 1,1,0,0, !MSG, 0,2,0,1, 0,7,0,0, MSG ? 0 : 1, 0};
        vecs[10] = '{4, 0,1,0,0, 1, 0,2,0,1, 0,8,0,0, 1, 0};
        vecs[11] = '{0, 0,0,1,0, 1, 0,2,0,1, 0,8,0,1, 1, 0};
        vecs[12] = '{0, 0,1,0,1, 1, 0,2,0,1, 0,8,0,1, 1, 0};
        vecs[13] = '{0, 1,0,0,0, 1, 0,2,0,1, 0,8,0,1, 0, 0};
        vecs[14] = '{0, 0,0,0,1, 1, 0,2,0,1, 0,8,0,1, 0, 1};

        // Reset state and tick spacing over 240 cycles.
        do_reset();
        chk("rst_sec", sec, 0);
        chk("rst_time", {H1, H2, min1, min2}, 0);
        chk("rst_alarm", {AH1, AH2, Amin1, Amin2}, 14'h0700);
        chk("rst_flags", {condition, armed, buzzer}, 0);
        begin
            int bad = 0;
            for (int n = 1; n <= 240; n++) begin
                @(negedge clk);
                if (sec != 6'((n / 4) % 60) || min2 != 4'(n / 240)) bad++;
            end
            chk("tick_spacing_bad_cycles", bad, 0);
            chk("t240_sec", sec, 0);
            chk("t240_min2", min2, 1);
            $display("seq tick_spacing done");
        end

        // Button table.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            repeat (vecs[i].wait_cyc) @(negedge clk);
            press(vecs[i].mode, vecs[i].hour, vecs[i].mn, vecs[i].stop);
            if (vecs[i].chk_time)
                chk($sformatf("vec%0d_time", i), {H1, H2, min1, min2},
                    {vecs[i].h1[2:0], vecs[i].h2[3:0], vecs[i].m1[3:0], vecs[i].m2[3:0]});
            chk($sformatf("vec%0d_alarm", i), {AH1, AH2, Amin1, Amin2},
                {vecs[i].ah1[1:0], vecs[i].ah2[3:0], vecs[i].am1[3:0], vecs[i].am2[3:0]});
            chk($sformatf("vec%0d_cond", i), condition, vecs[i].cond);
            chk($sformatf("vec%0d_armed", i), armed, vecs[i].arm);
            $display("vec %0d applied m=%0b h=%0b mn=%0b s=%0b", i,
                     vecs[i].mode, vecs[i].hour, vecs[i].mn, vecs[i].stop);
        end

        // 23:59:59 -> 00:00:00 rollover.
        setup_time(23, 59, 0);
        repeat (3) @(negedge clk);
        chk("roll_pre_time", {H1, H2, min1, min2}, 15'h2359);
        chk("roll_pre_sec", sec, 59);
        @(negedge clk);
        chk("roll_time", {H1, H2, min1, min2}, 0);
        chk("roll_sec", sec, 0);
        $display("seq rollover done");

        // Alarm trigger at 07:00:00 and timeout after RING_SECS ticks.
        setup_time(6, 59, 1);
        chk("trig_armed", armed, 1);
        repeat (3) @(negedge clk);
        chk("trig_pre_buzzer", buzzer, 0);
        @(negedge clk);
        chk("trig_buzzer", buzzer, 1);
        chk("trig_sec", sec, 0);
        chk_ring_display("trig");
        repeat (11) @(negedge clk);
        chk("ring_last_buzzer", buzzer, 1);
        @(negedge clk);
        chk("ring_timeout_buzzer", buzzer, 0);
        chk("ring_timeout_armed", armed, 1);
        chk("ring_timeout_sec", sec, 3);
        chk("ring_timeout_time", {H1, H2, min1, min2}, 15'h0700);
        $display("seq ring_timeout done");

        // btn_mode ignored in RING, btn_stop ends it.
        setup_time(6, 59, 1);
        repeat (4) @(negedge clk);
        chk("stop_ring_entered", buzzer, 1);
        press(1, 0, 0, 0);
        chk("ring_mode_ignored", buzzer, 1);
        chk("ring_mode_cond", condition, 0);
        press(0, 0, 0, 1);
        chk("ring_stop_buzzer", buzzer, 0);
        chk("ring_stop_armed", armed, 1);
        repeat (6) @(negedge clk);
        chk("after_stop_buzzer", buzzer, 0);
        chk("after_stop_sec", sec, 2);
        $display("seq ring_stop done");

        // btn_stop on the trigger edge disarms and suppresses the ring.
        setup_time(6, 59, 1);
        repeat (3) @(negedge clk);
        press(0, 0, 0, 1);
        chk("stoptrig_armed", armed, 0);
        chk("stoptrig_buzzer", buzzer, 0);
        chk("stoptrig_time", {H1, H2, min1, min2, 2'b00, sec}, {15'h0700, 8'h00});
        repeat (4) @(negedge clk);
        chk("stoptrig_later_buzzer", buzzer, 0);
        $display("seq stop_on_trigger done");

        // Alarm digit wrap.
        do_reset();
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        repeat (17) press(0, 1, 0, 0);
        chk("ahour_wrap", {AH1, AH2}, 0);
        repeat (23) press(0, 1, 0, 0);
        chk("ahour_23", {AH1, AH2}, 6'h23);
        repeat (59) press(0, 0, 1, 0);
        chk("amin_59", {Amin1, Amin2}, 8'h59);
        press(0, 0, 1, 0);
        chk("amin_wrap", {Amin1, Amin2}, 0);
        chk("amin_wrap_hours", {AH1, AH2}, 6'h23);
        $display("seq alarm_wrap done");

`ifdef ALARM_MSG_EN
        // SET_ALARM message window.
        do_reset();
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            chk($sformatf("seta_msg%0d", c), {H1, H2, min1, min2}, 15'b011_1010_1010_1010);
            chk($sformatf("seta_cond%0d", c), condition, 0);
        end
        @(negedge clk);
        chk("seta_end_cond", condition, 1);
        chk("seta_end_time", {H1, H2, min1, min2}, 0);
        $display("seq seta_message done");
`endif

        // Reset in the middle of RING.
        setup_time(6, 59, 1);
        repeat (6) @(negedge clk);
        chk("midring_buzzer", buzzer, 1);
        chk_ring_display("midring");
        do_reset();
        chk("midring_rst_time", {H1, H2, min1, min2, 2'b00, sec}, 0);
        chk("midring_rst_flags", {condition, armed, buzzer}, 0);
        press(0, 0, 0, 1);
        chk("midring_rst_clock_state", armed, 1);
        $display("seq midring_reset done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
